// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/load-store single-port memory arbiter with starvation guard and timeout
module mem_port_arbiter #(
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int LS_STREAK_MAX = 4,
    parameter int TIMEOUT       = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic [DW-1:0] ls_rdata,
    output logic          ls_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          err
);

    localparam int SW = (LS_STREAK_MAX > 0) ? $clog2(LS_STREAK_MAX + 1) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(LS_STREAK_MAX);
    localparam logic [CW-1:0] CNT_LAST   = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t        state_q,     state_d;
    logic [SW-1:0] streak_q,    streak_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic          grant_ls_q,  grant_ls_d;
    logic [AW-1:0] addr_q,      addr_d;
    logic [DW-1:0] wdata_q,     wdata_d;
    logic          we_q,        we_d;
    logic [DW-1:0] if_rdata_q,  if_rdata_d;
    logic [DW-1:0] ls_rdata_q,  ls_rdata_d;
    logic          if_ready_q,  if_ready_d;
    logic          ls_ready_q,  ls_ready_d;
    logic          err_q,       err_d;
    logic          mem_en_q,    mem_en_d;
    logic          mem_we_q,    mem_we_d;

    // Load/store wins unless fetch has been passed over LS_STREAK_MAX times in a row
    logic pick_ls;
    always_comb begin
        pick_ls = ls_req && !(if_req && (streak_q == STREAK_MAX));
    end

    // Next-state and next-output computation; every output is registered
    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        cnt_d      = cnt_q;
        grant_ls_d = grant_ls_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        if_ready_d = 1'b0;
        ls_ready_d = 1'b0;
        err_d      = 1'b0;
        mem_en_d   = 1'b0;
        mem_we_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (if_req || ls_req) begin
                    grant_ls_d = pick_ls;
                    addr_d     = pick_ls ? ls_addr : if_addr;
                    wdata_d    = pick_ls ? ls_wdata : '0;
                    we_d       = pick_ls && ls_we;
                    // Streak only counts grants that actually made fetch wait
                    if (pick_ls && if_req) begin
                        streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + 1'b1;
                    end else begin
                        streak_d = '0;
                    end
                    cnt_d    = '0;
                    mem_en_d = 1'b1;
                    mem_we_d = pick_ls && ls_we;
                    state_d  = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                if (mem_ack) begin
                    if (grant_ls_q) begin
                        ls_rdata_d = mem_rdata;
                        ls_ready_d = 1'b1;
                    end else begin
                        if_rdata_d = mem_rdata;
                        if_ready_d = 1'b1;
                    end
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    // Abort: the winner still gets its ready, with zero data and err
                    if (grant_ls_q) begin
                        ls_rdata_d = '0;
                        ls_ready_d = 1'b1;
                    end else begin
                        if_rdata_d = '0;
                        if_ready_d = 1'b1;
                    end
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                    mem_en_d = 1'b1;
                    mem_we_d = we_q;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; rst overrides everything and abandons any access
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            streak_q   <= '0;
            cnt_q      <= '0;
            grant_ls_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
            if_ready_q <= 1'b0;
            ls_ready_q <= 1'b0;
            err_q      <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            cnt_q      <= cnt_d;
            grant_ls_q <= grant_ls_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
            if_ready_q <= if_ready_d;
            ls_ready_q <= ls_ready_d;
            err_q      <= err_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_ready  = if_ready_q;
    assign ls_rdata  = ls_rdata_q;
    assign ls_ready  = ls_ready_q;
    assign err       = err_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: AW, 32, address width in bits.
REQ-002 Parameter: DW, 32, data width in bits.
REQ-003 Parameter: LS_STREAK_MAX, 4, maximum number of consecutive load/store grants while fetch waits.
REQ-004 Parameter: TIMEOUT, 64, maximum ACCESS cycles before abort.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 if_req  in  1  instruction-fetch request, held until if_ready.
REQ-008 if_addr  in  AW  fetch address; stable while if_req is high.
REQ-009 if_rdata  out  DW  fetched word; valid when if_ready=1.
REQ-010 if_ready  out  1  one-cycle completion pulse for fetch.
REQ-011 ls_req  in  1  load/store request, held until ls_ready.
REQ-012 ls_we  in  1  1 = store, 0 = load.
REQ-013 ls_addr  in  AW  load/store address.
REQ-014 ls_wdata  in  DW  store data.
REQ-015 ls_rdata  out  DW  load data; valid when ls_ready=1.
REQ-016 ls_ready  out  1  one-cycle completion pulse for load/store.
REQ-017 mem_en  out  1  memory access active; held high until mem_ack.
REQ-018 mem_we  out  1  memory write strobe; qualified by mem_en.
REQ-019 mem_addr  out  AW  memory address.
REQ-020 mem_wdata  out  DW  memory write data.
REQ-021 mem_rdata  in  DW  memory read data; valid with mem_ack.
REQ-022 mem_ack  in  1  memory completion; may assert in the first ACCESS cycle or any later cycle.
REQ-023 err  out  1  one-cycle pulse, coincident with ready, when an access timed out.

Function
REQ-024 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-025 In IDLE, if any request is high, the block SHALL latch the winner's address, write data and write enable, and SHALL move to ACCESS on the next edge.
REQ-026 Arbitration SHALL give priority to ls_req, except that fetch SHALL win when ls_streak equals LS_STREAK_MAX and if_req is high.
REQ-027 ls_streak SHALL increment on each load/store grant while if_req is high; it SHALL clear on any fetch grant and whenever if_req is low at grant; it SHALL saturate at LS_STREAK_MAX.
REQ-028 In ACCESS, mem_en SHALL be 1 and mem_addr, mem_we and mem_wdata SHALL come from the latched registers; these SHALL not depend on live request inputs.
REQ-029 mem_we SHALL be 0 for all fetch grants.
REQ-030 In ACCESS, when mem_ack=1, the block SHALL register mem_rdata into the winner's rdata register and SHALL move to RESP.
REQ-031 The timeout counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without mem_ack.
REQ-032 When the counter reaches TIMEOUT-1 without mem_ack, the block SHALL move to RESP with rdata set to 0 and err armed.
REQ-033 In RESP, exactly the winner's ready SHALL be 1 for one cycle, and err SHALL be 1 if armed; the next state SHALL be IDLE.
REQ-034 Outside RESP, both ready outputs and err SHALL be 0; outside ACCESS, mem_en and mem_we SHALL be 0.
REQ-035 Minimum latency SHALL be: request seen in IDLE at cycle 0, mem_ack in cycle 1, ready in cycle 2.
REQ-036 Back-to-back operation SHALL take at least 3 cycles per access; IDLE SHALL last one cycle when a request is pending.
REQ-037 Requests that arrive during ACCESS or RESP SHALL be held pending and SHALL be arbitrated in the next IDLE.
REQ-038 if_rdata and ls_rdata SHALL hold their last value until overwritten by that port's own completion.
REQ-039 mem_ack in IDLE or RESP SHALL be ignored.

Reset
REQ-040 On rst=1 at a clock edge: state SHALL become IDLE, ls_streak and the timeout counter SHALL become 0, and err, both ready outputs, mem_en and mem_we SHALL become 0.
REQ-041 On that reset, if_rdata, ls_rdata and the latched address and write data SHALL become 0.
REQ-042 A reset during ACCESS or RESP SHALL abandon the access with no ready pulse; rst SHALL have priority over every other input.

Verification
REQ-043 Single fetch: if_req=1, if_addr=0x10, mem_ack in cycle 1 with mem_rdata=0xDEADBEEF -> if_ready=1 and if_rdata=0xDEADBEEF in cycle 2, mem_we=0 throughout.
REQ-044 Simultaneous request: if_req and ls_req both high in IDLE, ls_we=1, ls_addr=0x20, ls_wdata=0x55 -> store granted first with mem_we=1, mem_addr=0x20 and mem_wdata=0x55; fetch granted in the following IDLE.
REQ-045 Starvation guard: with LS_STREAK_MAX=4, ls_req held continuously with if_req high -> exactly 4 load/store grants, then 1 fetch grant, then the pattern repeats.
REQ-046 Timeout: with TIMEOUT=8 and mem_ack never asserted -> mem_en high for exactly 8 cycles, then ready=1, err=1 and rdata=0 for one cycle.
REQ-047 Reset mid-access: rst=1 in the 3rd ACCESS cycle -> next cycle IDLE, mem_en=0 and no ready pulse; a subsequent request completes normally.
REQ-048 Stray ack: mem_ack=1 while in IDLE with no request -> no state change and no ready pulse.
